fifo_param: RTL and testbench

// - Next-generation synchronous FIFO: parametrised width/depth, run-time almost-full/empty thresholds,

---
 rtl/fifo_param_pkg.sv | 14 +
 rtl/fifo_param_mem.sv | 24 ++
 rtl/fifo_param.sv | 133 +++++++++++++
 tb/tb_fifo_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared defaults and width helper for the parametrised FIFO.
// Count width is clog2(depth)+1 so a full FIFO can be represented.
package fifo_param_pkg;

  localparam int DEF_WORD_SIZE = 6;
  localparam int DEF_MEM_SIZE  = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [cnt_w(DEF_MEM_SIZE)-1:0] count_t;

endpackage

// File: rtl/fifo_param_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Read returns the pre-edge contents, so a same-edge write to the head slot is safe.
module fifo_param_mem #(
  parameter int W = 6,
  parameter int D = 8,
  parameter int A = $clog2(D)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [A-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem_q [D];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with thresholds, count and sticky errors.
// Define FIFO_PARAM_FWFT_EN for first-word fall-through reads.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int PTR_L     = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic                 fifo_rd,
  input  logic [PTR_L:0]       full_threshold,
  input  logic [PTR_L:0]       empty_threshold,
  input  logic                 error_clr,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 fifo_valid,
  output logic [PTR_L:0]       fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err_ovf,
  output logic                 err_udf,
  output logic                 error
);

  localparam int CW = PTR_L + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(MEM_SIZE);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PTR_L-1:0] PTR_ONE  = PTR_L'(1);

  logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_acc, wr_acc;
  logic [WORD_SIZE-1:0] head;

  assign fifo_count   = count_q;
  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= full_threshold);
  assign almost_empty = (count_q <= empty_threshold);
  assign err_ovf      = ovf_q;
  assign err_udf      = udf_q;
  assign error        = ovf_q | udf_q;

  assign rd_acc = fifo_rd & ~fifo_empty;
  assign wr_acc = fifo_wr & (~fifo_full | rd_acc);

  fifo_param_mem #(
    .W(WORD_SIZE),
    .D(MEM_SIZE),
    .A(PTR_L)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc & ~reset),
    .wr_addr(wr_ptr_q),
    .wr_data(fifo_data_in),
    .rd_addr(rd_ptr_q),
    .rd_data(head)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case (1'b1)
      wr_acc & ~rd_acc: count_d = count_q + CNT_ONE;
      rd_acc & ~wr_acc: count_d = count_q - CNT_ONE;
      default:          count_d = count_q;
    endcase
    // set events take priority over a same-cycle clear
    if (error_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (fifo_wr & fifo_full & ~rd_acc) ovf_d = 1'b1;
    if (fifo_rd & fifo_empty)          udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign fifo_data_out = head;
  assign fifo_valid    = ~fifo_empty;
`else
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = rd_acc;
    if (rd_acc) data_d = head;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign fifo_data_out = data_q;
  assign fifo_valid    = valid_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed and scoreboard bench for fifo_param.
// Read checks adapt when FIFO_PARAM_FWFT_EN is defined.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset, fifo_wr, fifo_rd, error_clr;
  logic [5:0] fifo_data_in, fifo_data_out;
  logic [3:0] full_threshold, empty_threshold, fifo_count;
  logic       fifo_valid, fifo_full, fifo_empty;
  logic       almost_full, almost_empty;
  logic       err_ovf, err_udf, error;

  int n_run  = 0;
  int n_fail = 0;

  fifo_param dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_wr        (fifo_wr),
    .fifo_data_in   (fifo_data_in),
    .fifo_rd        (fifo_rd),
    .full_threshold (full_threshold),
    .empty_threshold(empty_threshold),
    .error_clr      (error_clr),
    .fifo_data_out  (fifo_data_out),
    .fifo_valid     (fifo_valid),
    .fifo_count     (fifo_count),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .err_ovf        (err_ovf),
    .err_udf        (err_udf),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop(input logic [5:0] exp);
`ifdef FIFO_PARAM_FWFT_EN
    chk("pop_valid", fifo_valid, 1);
    chk("pop_data", fifo_data_out, exp);
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
`else
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    chk("pop_valid", fifo_valid, 1);
    chk("pop_data", fifo_data_out, exp);
`endif
  endtask

  logic [5:0] q[$];
  logic       m_ovf, m_udf, w, r, ra, wa;
  logic [5:0] d, exp_d;

  initial begin
    reset = 1'b1; fifo_wr = 1'b0; fifo_rd = 1'b0;
    error_clr = 1'b0; fifo_data_in = '0;
    full_threshold = 4'd6; empty_threshold = 4'd2;
    step();
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_err", error, 0);
`ifndef FIFO_PARAM_FWFT_EN
    chk("rst_valid", fifo_valid, 0);
    chk("rst_data", fifo_data_out, 0);
`endif
    reset = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      fifo_wr = 1'b1; fifo_data_in = 6'(i);
      step();
      chk("fill_count", fifo_count, i);
      chk("fill_ae", almost_empty, i <= 2);
      chk("fill_af", almost_full, i >= 6);
      chk("fill_full", fifo_full, i == 8);
`ifdef FIFO_PARAM_FWFT_EN
      chk("fwft_head", fifo_data_out, 1);
      chk("fwft_valid", fifo_valid, 1);
`endif
    end
    chk("fill_err", error, 0);

    fifo_data_in = 6'h3F;
    step();
    fifo_wr = 1'b0;
    chk("ovf_flag", err_ovf, 1);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_error", error, 1);
    error_clr = 1'b1;
    step();
    error_clr = 1'b0;
    chk("ovf_clr", error, 0);

    for (int i = 1; i <= 8; i++) pop(6'(i));
    chk("drain_empty", fifo_empty, 1);
`ifndef FIFO_PARAM_FWFT_EN
    step();
    chk("idle_valid", fifo_valid, 0);
    chk("idle_hold", fifo_data_out, 8);
`else
    chk("idle_valid", fifo_valid, 0);
`endif

    fifo_rd = 1'b1;
    step();
    chk("udf_flag", err_udf, 1);
    chk("udf_error", error, 1);
    error_clr = 1'b1;
    step();
    chk("clr_vs_set", err_udf, 1);
    fifo_rd = 1'b0;
    step();
    error_clr = 1'b0;
    chk("udf_clr", error, 0);

    for (int i = 0; i < 8; i++) begin
      fifo_wr = 1'b1; fifo_data_in = 6'h10 + 6'(i);
      step();
    end
    fifo_rd = 1'b1; fifo_data_in = 6'h2A;
`ifdef FIFO_PARAM_FWFT_EN
    chk("rw_full_head", fifo_data_out, 6'h10);
`endif
    step();
    fifo_rd = 1'b0; fifo_wr = 1'b0;
    chk("rw_full_cnt", fifo_count, 8);
    chk("rw_full_err", error, 0);
`ifndef FIFO_PARAM_FWFT_EN
    chk("rw_full_data", fifo_data_out, 6'h10);
`endif
    for (int i = 1; i < 8; i++) pop(6'h10 + 6'(i));
    pop(6'h2A);
    chk("rw_drain_cnt", fifo_count, 0);

    fifo_rd = 1'b1; fifo_wr = 1'b1; fifo_data_in = 6'h15;
    step();
    fifo_rd = 1'b0; fifo_wr = 1'b0;
    chk("rw_empty_udf", err_udf, 1);
    chk("rw_empty_cnt", fifo_count, 1);
`ifndef FIFO_PARAM_FWFT_EN
    chk("rw_empty_vld", fifo_valid, 0);
`endif
    pop(6'h15);
    error_clr = 1'b1;
    step();
    error_clr = 1'b0;

    full_threshold = 4'd0;
    #1;
    chk("thr_af_now", almost_full, 1);
    empty_threshold = 4'd0;
    #1;
    chk("thr_ae_now", almost_empty, 1);
    full_threshold = 4'd6; empty_threshold = 4'd2;

    m_ovf = 1'b0; m_udf = 1'b0;
    for (int k = 0; k < 40; k++) begin
      w = ($urandom % 8) != 0;
      r = ($urandom % 8) < 6;
      d = 6'($urandom % 64);
`ifdef FIFO_PARAM_FWFT_EN
      chk("sb_valid", fifo_valid, q.size() > 0);
      if (q.size() > 0) chk("sb_head", fifo_data_out, q[0]);
`endif
      ra = r && q.size() > 0;
      wa = w && (q.size() < 8 || ra);
      if (w && q.size() == 8 && !ra) m_ovf = 1'b1;
      if (r && q.size() == 0) m_udf = 1'b1;
      exp_d = '0;
      if (ra) exp_d = q.pop_front();
      if (wa) q.push_back(d);
      fifo_wr = w; fifo_rd = r; fifo_data_in = d;
      step();
      chk("sb_count", fifo_count, q.size());
      chk("sb_full", fifo_full, q.size() == 8);
      chk("sb_empty", fifo_empty, q.size() == 0);
      chk("sb_af", almost_full, q.size() >= 6);
      chk("sb_ae", almost_empty, q.size() <= 2);
      chk("sb_ovf", err_ovf, m_ovf);
      chk("sb_udf", err_udf, m_udf);
`ifndef FIFO_PARAM_FWFT_EN
      chk("sb_valid", fifo_valid, ra);
      if (ra) chk("sb_data", fifo_data_out, exp_d);
`endif
    end
    fifo_wr = 1'b0; fifo_rd = 1'b0;

    reset = 1'b1;
    step();
    reset = 1'b0;
    fifo_rd = 1'b1;
    step();
    fifo_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fifo_wr = 1'b1; fifo_data_in = 6'h20 + 6'(i);
      step();
    end
    chk("pre_rst_cnt", fifo_count, 5);
    fifo_rd = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0;
    chk("mid_rst_cnt", fifo_count, 0);
    chk("mid_rst_empty", fifo_empty, 1);
    chk("mid_rst_full", fifo_full, 0);
    chk("mid_rst_err", error, 0);
    chk("mid_rst_ae", almost_empty, 1);
    chk("mid_rst_af", almost_full, 0);
`ifndef FIFO_PARAM_FWFT_EN
    chk("mid_rst_vld", fifo_valid, 0);
    chk("mid_rst_data", fifo_data_out, 0);
`else
    chk("mid_rst_vld", fifo_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
